hpi_responder: RTL and testbench
================================

// Module: hpi_responder
// PURPOSE
//  Synthesizable responder for the EZ-OTG host port interface (HPI): answers the
//  address/cs/r/w/data transactions the NIOS PIOs issue, in place of the USB chip.
//  Holds a word RAM, auto-incrementing ADDRESS pointer, two mailboxes and STATUS.
//  A local port lets fabric logic preload keyboard reports for driver bring-up.
// PARAMETERS
//  MEM_WORDS   256  16-bit words of RAM (power of two); HPI byte address wraps modulo 2*MEM_WORDS
//  AW          8    log2(MEM_WORDS)
// PORTS
//  Clk         in   1   system clock; all HPI inputs are synchronous to it
//  Reset       in   1   synchronous active-high reset
//  hpi_addr    in   2   00 DATA, 01 MAILBOX, 10 ADDRESS, 11 STATUS
//  hpi_cs_n    in   1   chip select, active low
//  hpi_r_n     in   1   read strobe, active low
//  hpi_w_n     in   1   write strobe, active low
//  hpi_rst_n   in   1   chip reset from host, active low
//  hpi_din     in   16  host-to-responder data
//  hpi_dout    out  16  responder-to-host data
//  loc_we      in   1   local RAM write request
//  loc_addr    in   AW  local word address
//  loc_wdata   in   16  local write data
//  loc_ack     out  1   one-cycle pulse: local write committed
//  loc_rdata   out  16  RAM[loc_addr], registered, 1-cycle latency
//  mbx_wr      in   1   local write to host mailbox (MBX_IN)
//  mbx_wdata   in   16  value for MBX_IN
//  mbx_out     out  16  last mailbox value written by host
//  mbx_out_vld out  1   pulse when host writes MAILBOX
// BEHAVIOUR
//  Reset, or hpi_rst_n low when sampled: ADDR_PTR=0, MBX_IN=0, mbx_out=0, flags=0,
//   hpi_dout=0, loc_ack=0, mbx_out_vld=0, FSM=IDLE. RAM contents unaffected.
//  FSM IDLE / RD / WR / ERR; strobes qualified by hpi_cs_n=0.
//   IDLE: r_n=0,w_n=1 -> RD; w_n=0,r_n=1 -> WR; both 0 -> ERR, set ERR flag.
//   RD: cycle after entry hpi_dout = selected register (1-cycle latency), held
//    stable until r_n=1. On exit to IDLE, if DATA: ADDR_PTR += 2 (wraps).
//    Read of MAILBOX clears MBX_IN_FLAG on exit.
//   WR: hpi_din captured in entry cycle only; further cycles ignored. DATA ->
//    RAM[ADDR_PTR>>1], ADDR_PTR += 2; ADDRESS -> ADDR_PTR=din (bit0 forced 0);
//    MAILBOX -> mbx_out=din, mbx_out_vld pulses, MBX_OUT_FLAG=1; STATUS -> ignored.
//    Return to IDLE when w_n=1.
//   ERR: no register effects; back to IDLE when r_n=w_n=1. cs_n=1 in any state
//    aborts to IDLE with no post-increment and no side effects.
//  STATUS word: bit0 MBX_IN_FLAG, bit8 MBX_OUT_FLAG, bit15 ERR, others 0.
//   Reading STATUS clears ERR on exit; MBX_OUT_FLAG cleared by local mbx_wr.
//  mbx_wr: MBX_IN=mbx_wdata, MBX_IN_FLAG=1, MBX_OUT_FLAG=0 next cycle. If in the
//   same cycle a MAILBOX read exits, the set wins (flag stays 1).
//  Local port: loc_we commits in that cycle, loc_ack next cycle, unless a host
//   DATA write commits the same cycle: host wins, loc_ack stays 0, requester must
//   hold loc_we until ack. Same-address same-cycle -> host data stored.
//  Host DATA read returns RAM content as of the RD entry cycle.
// TESTING
//  1 Reset; write ADDRESS=0x0010, DATA=0xBEEF, DATA=0x1234 -> RAM[8]=BEEF,
//    RAM[9]=1234, ADDRESS read = 0x0014.
//  2 ADDRESS=0x01FE (MEM_WORDS=256), write DATA 0xAAAA twice -> RAM[255]=AAAA,
//    RAM[0]=AAAA, pointer wraps to 0x0002.
//  3 mbx_wr with 0x5A5A -> STATUS reads 0x0001; MAILBOX read returns 5A5A; STATUS
//    then 0x0000. Host MAILBOX write 0x00C3 -> mbx_out_vld 1 cycle, STATUS 0x0100.
//  4 r_n and w_n low together -> no RAM change, STATUS bit15=1, cleared after read.
//  5 loc_we to word 8 in same cycle as host DATA write to word 8 -> loc_ack=0,
//    RAM[8]=host data; held loc_we then acked next cycle, loc_rdata shows it.
//  6 hpi_rst_n low mid-RD of DATA -> hpi_dout=0, ADDR_PTR=0, no post-increment.

Source files
------------

// File: rtl/hpi_responder.sv
// hpi_responder: stands in for the EZ-OTG chip on the host port interface, with word RAM,
// auto-incrementing pointer, mailboxes, STATUS and a local preload port.
module hpi_responder #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [1:0]    hpi_addr,
    input  logic          hpi_cs_n,
    input  logic          hpi_r_n,
    input  logic          hpi_w_n,
    input  logic          hpi_rst_n,
    input  logic [15:0]   hpi_din,
    output logic [15:0]   hpi_dout,
    input  logic          loc_we,
    input  logic [AW-1:0] loc_addr,
    input  logic [15:0]   loc_wdata,
    output logic          loc_ack,
    output logic [15:0]   loc_rdata,
    input  logic          mbx_wr,
    input  logic [15:0]   mbx_wdata,
    output logic [15:0]   mbx_out,
    output logic          mbx_out_vld
);
    typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_e;
    localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2;
    localparam logic [AW:0] STEP = (AW+1)'(2);

    state_e        state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   mbx_in_q, mbx_in_d;
    logic [15:0]   mbx_out_q, mbx_out_d;
    logic [15:0]   dout_q, dout_d;
    logic          in_flag_q, in_flag_d;
    logic          out_flag_q, out_flag_d;
    logic          err_q, err_d;
    logic          vld_q, vld_d;
    logic          ack_q;
    logic [15:0]   rdata_q;
    logic [15:0]   mem [MEM_WORDS];
    logic          rst_all, host_we, loc_commit;
    logic [15:0]   status, rd_val;

    assign rst_all    = Reset | ~hpi_rst_n;
    assign status     = {err_q, 6'b0, out_flag_q, 7'b0, in_flag_q};
    assign rd_val     = hpi_addr == A_DATA ? mem[ptr_q[AW:1]] :
                        hpi_addr == A_MBX  ? mbx_in_q :
                        hpi_addr == A_ADDR ? 16'(ptr_q) : status;
    assign host_we    = ~rst_all & state_q == IDLE & ~hpi_cs_n & ~hpi_w_n & hpi_r_n & hpi_addr == A_DATA;
    assign loc_commit = ~rst_all & loc_we & ~host_we;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        mbx_in_d   = mbx_in_q;
        mbx_out_d  = mbx_out_q;
        dout_d     = dout_q;
        in_flag_d  = in_flag_q;
        out_flag_d = out_flag_q;
        err_d      = err_q;
        vld_d      = 1'b0;
        // Local mailbox update first so a same-cycle host MAILBOX write still sets its flag
        if (mbx_wr) begin
            mbx_in_d   = mbx_wdata;
            in_flag_d  = 1'b1;
            out_flag_d = 1'b0;
        end
        case (state_q)
            IDLE: if (!hpi_cs_n) begin
                if (!hpi_r_n && !hpi_w_n) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (!hpi_r_n) begin
                    state_d = RD;
                    sel_d   = hpi_addr;
                    dout_d  = rd_val;
                end else if (!hpi_w_n) begin
                    state_d = WR;
                    case (hpi_addr)
                        A_DATA: ptr_d = ptr_q + STEP;
                        A_ADDR: ptr_d = {hpi_din[AW:1], 1'b0};
                        A_MBX: begin
                            mbx_out_d  = hpi_din;
                            vld_d      = 1'b1;
                            out_flag_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RD: if (hpi_cs_n) state_d = IDLE;
                else if (hpi_r_n) begin
                    state_d = IDLE;
                    case (sel_q)
                        A_DATA:  ptr_d = ptr_q + STEP;
                        A_MBX:   in_flag_d = mbx_wr;
                        A_ADDR:  ;
                        default: err_d = 1'b0;
                    endcase
                end
            WR:  state_d = (hpi_cs_n || hpi_w_n) ? IDLE : WR;
            ERR: state_d = (hpi_cs_n || (hpi_r_n && hpi_w_n)) ? IDLE : ERR;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst_all) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_q      <= A_DATA;
            mbx_in_q   <= '0;
            mbx_out_q  <= '0;
            dout_q     <= '0;
            in_flag_q  <= 1'b0;
            out_flag_q <= 1'b0;
            err_q      <= 1'b0;
            vld_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            mbx_in_q   <= mbx_in_d;
            mbx_out_q  <= mbx_out_d;
            dout_q     <= dout_d;
            in_flag_q  <= in_flag_d;
            out_flag_q <= out_flag_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
            ack_q      <= loc_commit;
        end
    end

    // Host DATA write has priority on the single RAM write port
    always_ff @(posedge Clk) begin
        if (host_we) mem[ptr_q[AW:1]] <= hpi_din;
        else if (loc_commit) mem[loc_addr] <= loc_wdata;
        rdata_q <= mem[loc_addr];
    end

    assign hpi_dout    = dout_q;
    assign loc_ack     = ack_q;
    assign loc_rdata   = rdata_q;
    assign mbx_out     = mbx_out_q;
    assign mbx_out_vld = vld_q;
endmodule

// File: tb/tb_hpi_responder.sv
// tb_hpi_responder: scoreboard bench for hpi_responder; read expectations are queued
// when a read is issued and compared when the DUT presents the data.
module tb_hpi_responder;
    localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2, A_STAT = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  hpi_addr = '0;
    logic        hpi_cs_n = 1'b1, hpi_r_n = 1'b1, hpi_w_n = 1'b1, hpi_rst_n = 1'b1;
    logic [15:0] hpi_din = '0, hpi_dout;
    logic        loc_we = 1'b0, loc_ack;
    logic [7:0]  loc_addr = '0;
    logic [15:0] loc_wdata = '0, loc_rdata;
    logic        mbx_wr = 1'b0, mbx_out_vld;
    logic [15:0] mbx_wdata = '0, mbx_out;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    hpi_responder dut (
        .Clk(clk), .Reset(rst), .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n),
        .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_rst_n(hpi_rst_n),
        .hpi_din(hpi_din), .hpi_dout(hpi_dout), .loc_we(loc_we),
        .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_ack(loc_ack),
        .loc_rdata(loc_rdata), .mbx_wr(mbx_wr), .mbx_wdata(mbx_wdata),
        .mbx_out(mbx_out), .mbx_out_vld(mbx_out_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] got);
        if (exp_q.size() == 0) chk({tag, "_empty_sb"}, got, 16'hxxxx ^ got ^ 16'hffff);
        else chk(tag, got, exp_q.pop_front());
    endtask

    task automatic host_write(input logic [1:0] a, input logic [15:0] d);
        hpi_addr = a; hpi_din = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        cyc();
        hpi_w_n = 1'b1; hpi_cs_n = 1'b1;
        cyc();
    endtask

    task automatic host_read(input string tag, input logic [1:0] a, input logic [15:0] exp);
        exp_q.push_back(exp);
        hpi_addr = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        cyc();
        pop_chk(tag, hpi_dout);
        cyc();
        chk({tag, "_hold"}, hpi_dout, exp);
        hpi_r_n = 1'b1;
        cyc();
        hpi_cs_n = 1'b1;
    endtask

    task automatic loc_write(input logic [7:0] a, input logic [15:0] d);
        bit acked = 0;
        loc_addr = a; loc_wdata = d; loc_we = 1'b1;
        for (int i = 0; i < 10 && !acked; i++) begin
            cyc();
            acked = loc_ack;
        end
        loc_we = 1'b0;
        if (!acked) chk("loc_ack_timeout", 16'(loc_ack), 16'd1);
    endtask

    task automatic loc_read(input string tag, input logic [7:0] a, input logic [15:0] exp);
        exp_q.push_back(exp);
        loc_addr = a;
        cyc();
        pop_chk(tag, loc_rdata);
    endtask

    initial begin
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_dout", hpi_dout, 16'h0000);
        chk("rst_ack", 16'(loc_ack), 16'h0);
        chk("rst_mbx_out", mbx_out, 16'h0000);
        chk("rst_vld", 16'(mbx_out_vld), 16'h0);
        host_read("rst_status", A_STAT, 16'h0000);
        host_read("rst_addr", A_ADDR, 16'h0000);

        host_write(A_ADDR, 16'h0010);
        host_write(A_DATA, 16'hBEEF);
        host_write(A_DATA, 16'h1234);
        loc_read("t1_ram8", 8'd8, 16'hBEEF);
        loc_read("t1_ram9", 8'd9, 16'h1234);
        host_read("t1_addr", A_ADDR, 16'h0014);
        host_write(A_ADDR, 16'h0011);
        host_read("t1_data_rd", A_DATA, 16'hBEEF);
        host_read("t1_addr_inc", A_ADDR, 16'h0012);

        host_write(A_ADDR, 16'h01FE);
        host_write(A_DATA, 16'hAAAA);
        host_write(A_DATA, 16'hAAAA);
        loc_read("t2_ram255", 8'd255, 16'hAAAA);
        loc_read("t2_ram0", 8'd0, 16'hAAAA);
        host_read("t2_wrap", A_ADDR, 16'h0002);

        mbx_wdata = 16'h5A5A; mbx_wr = 1'b1;
        cyc();
        mbx_wr = 1'b0;
        host_read("t3_stat_in", A_STAT, 16'h0001);
        host_read("t3_mbx_rd", A_MBX, 16'h5A5A);
        host_read("t3_stat_clr", A_STAT, 16'h0000);
        hpi_addr = A_MBX; hpi_din = 16'h00C3; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        cyc();
        chk("t3_vld", 16'(mbx_out_vld), 16'h1);
        chk("t3_mbx_out", mbx_out, 16'h00C3);
        hpi_w_n = 1'b1; hpi_cs_n = 1'b1;
        cyc();
        chk("t3_vld_pulse", 16'(mbx_out_vld), 16'h0);
        host_read("t3_stat_out", A_STAT, 16'h0100);
        mbx_wdata = 16'h0101; mbx_wr = 1'b1;
        cyc();
        mbx_wr = 1'b0;
        host_read("t3_stat_swap", A_STAT, 16'h0001);
        exp_q.push_back(16'h0101);
        hpi_addr = A_MBX; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        cyc();
        pop_chk("t3_mbx_race_rd", hpi_dout);
        hpi_r_n = 1'b1; mbx_wdata = 16'h0202; mbx_wr = 1'b1;
        cyc();
        mbx_wr = 1'b0; hpi_cs_n = 1'b1;
        cyc();
        host_read("t3_race_flag", A_STAT, 16'h0001);
        host_read("t3_race_mbx", A_MBX, 16'h0202);
        host_read("t3_race_clr", A_STAT, 16'h0000);

        host_write(A_ADDR, 16'h0020);
        loc_write(8'd16, 16'h7777);
        hpi_addr = A_DATA; hpi_din = 16'hDEAD; hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
        cyc(); cyc();
        hpi_r_n = 1'b1; hpi_w_n = 1'b1; hpi_cs_n = 1'b1;
        cyc();
        loc_read("t4_ram16", 8'd16, 16'h7777);
        host_read("t4_err", A_STAT, 16'h8000);
        host_read("t4_err_clr", A_STAT, 16'h0000);
        host_read("t4_addr", A_ADDR, 16'h0020);

        host_write(A_ADDR, 16'h0010);
        hpi_addr = A_DATA; hpi_din = 16'h1111; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        loc_we = 1'b1; loc_addr = 8'd8; loc_wdata = 16'h2222;
        cyc();
        chk("t5_ack_lost", 16'(loc_ack), 16'h0);
        hpi_w_n = 1'b1; hpi_cs_n = 1'b1;
        cyc();
        chk("t5_ack", 16'(loc_ack), 16'h1);
        chk("t5_host_data", loc_rdata, 16'h1111);
        loc_we = 1'b0;
        cyc();
        chk("t5_ack_pulse", 16'(loc_ack), 16'h0);
        chk("t5_loc_data", loc_rdata, 16'h2222);

        host_write(A_ADDR, 16'h0030);
        loc_write(8'd24, 16'h4242);
        exp_q.push_back(16'h4242);
        hpi_addr = A_DATA; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        cyc();
        pop_chk("t6_abort_rd", hpi_dout);
        hpi_cs_n = 1'b1;
        cyc();
        hpi_r_n = 1'b1;
        host_read("t6_abort_ptr", A_ADDR, 16'h0030);
        exp_q.push_back(16'h4242);
        hpi_addr = A_DATA; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        cyc();
        pop_chk("t6_rd", hpi_dout);
        hpi_rst_n = 1'b0;
        cyc();
        chk("t6_dout_rst", hpi_dout, 16'h0000);
        hpi_rst_n = 1'b1; hpi_r_n = 1'b1; hpi_cs_n = 1'b1;
        cyc();
        host_read("t6_ptr_rst", A_ADDR, 16'h0000);
        loc_read("t6_ram_kept", 8'd24, 16'h4242);

        if (exp_q.size() != 0) chk("sb_leftover", 16'(exp_q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
